// File: rtl/alu_op_sequencer_if.sv
// Request, response and ALU-drive signals of the ALU op sequencer.
// slave: the sequencer side; master: the control pipeline / ALU side.
interface alu_op_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_opcode;
    logic [WIDTH-1:0] req_i1;
    logic [WIDTH-1:0] req_i2;
    logic [WIDTH-1:0] alu_i1;
    logic [WIDTH-1:0] alu_i2;
    logic [1:0]       alu_opcode;
    logic [WIDTH-1:0] alu_o1;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport slave (
        input  req_valid, req_opcode, req_i1, req_i2, alu_o1, rsp_ready,
        output req_ready, alu_i1, alu_i2, alu_opcode, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_opcode, req_i1, req_i2, alu_o1, rsp_ready,
        input  req_ready, alu_i1, alu_i2, alu_opcode, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives a combinational ALU, waits opcode-dependent settle cycles, returns the result.
// Optional macro ALU_SEQ_OPC_TRACK_EN: charge OPC_WAIT only when the opcode changes.
module alu_op_sequencer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADD_WAIT  = 3,
    parameter int unsigned PASS_WAIT = 1,
    parameter int unsigned OPC_WAIT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.slave   bus,
    output logic                busy
);
    localparam int unsigned CntW = $clog2(ADD_WAIT + PASS_WAIT + OPC_WAIT + 2);

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] i1_q, i1_d, i2_q, i2_d, data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic             err_q, err_d;
    int unsigned      base_wait, n_wait;

`ifdef ALU_SEQ_OPC_TRACK_EN
    logic [1:0] last_op_q, last_op_d;

    always_ff @(posedge clk) begin
        if (rst) last_op_q <= 2'b00;
        else     last_op_q <= last_op_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            i1_q    <= '0;
            i2_q    <= '0;
            op_q    <= 2'b00;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            op_q    <= op_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        base_wait = (bus.req_opcode == 2'b00) ? ADD_WAIT : PASS_WAIT;
`ifdef ALU_SEQ_OPC_TRACK_EN
        n_wait = base_wait + ((bus.req_opcode != last_op_q) ? OPC_WAIT : 0);
`else
        n_wait = base_wait + OPC_WAIT;
`endif
        if (n_wait == 0) n_wait = 1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        i1_d    = i1_q;
        i2_d    = i2_q;
        op_d    = op_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef ALU_SEQ_OPC_TRACK_EN
        last_op_d = last_op_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    i1_d    = bus.req_i1;
                    i2_d    = bus.req_i2;
                    op_d    = bus.req_opcode;
                    cnt_d   = CntW'(n_wait);
                    err_d   = (bus.req_opcode == 2'b11);
`ifdef ALU_SEQ_OPC_TRACK_EN
                    last_op_d = bus.req_opcode;
`endif
                    state_d = StSettle;
                end
            end
            StSettle: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    // Reserved opcode never exposes whatever the ALU drives.
                    data_d  = err_q ? '0 : bus.alu_o1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.rsp_valid  = (state_q == StResp);
    assign busy           = (state_q != StIdle);
    assign bus.alu_i1     = i1_q;
    assign bus.alu_i2     = i2_q;
    assign bus.alu_opcode = op_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_err    = err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a response scoreboard and an ALU model.
module tb_alu_op_sequencer;
    localparam int unsigned ADD_WAIT  = 3;
    localparam int unsigned PASS_WAIT = 1;
    localparam int unsigned OPC_WAIT  = 1;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [7:0]  data;
        logic        err;
        int unsigned lat;
    } exp_t;
    exp_t sb[$];

    logic [1:0] tb_last_op = 2'b00;

    alu_op_sequencer_if #(.WIDTH(8)) bus ();

    alu_op_sequencer #(
        .WIDTH(8), .ADD_WAIT(ADD_WAIT), .PASS_WAIT(PASS_WAIT), .OPC_WAIT(OPC_WAIT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [1:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a;
            2'b10:   return b;
            default: return 8'hFF;
        endcase
    endfunction

    assign bus.alu_o1 = alu_model(bus.alu_opcode, bus.alu_i1, bus.alu_i2);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request; returns in the first cycle after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned n;
        exp_t e;
        int k = 0;
        while (!bus.req_ready && k < 20) begin
            step();
            k++;
        end
        check("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_i1     = a;
        bus.req_i2     = b;
        step();
        bus.req_valid  = 1'b0;
        n = (op == 2'b00) ? ADD_WAIT : PASS_WAIT;
`ifdef ALU_SEQ_OPC_TRACK_EN
        if (op != tb_last_op) n += OPC_WAIT;
`else
        n += OPC_WAIT;
`endif
        if (n == 0) n = 1;
        tb_last_op = op;
        e.data = (op == 2'b11) ? 8'h00 : alu_model(op, a, b);
        e.err  = (op == 2'b11);
        e.lat  = n + 1;
        sb.push_back(e);
        check("alu_opcode_drive", {30'd0, bus.alu_opcode}, {30'd0, op});
        check("alu_i1_drive", {24'd0, bus.alu_i1}, {24'd0, a});
        check("alu_i2_drive", {24'd0, bus.alu_i2}, {24'd0, b});
        check("busy_settle", {31'd0, busy}, 32'd1);
    endtask

    // Waits for the response, compares against the scoreboard, optionally completes it.
    task automatic collect(input bit handshake, output int unsigned lat);
        exp_t e;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        check("rsp_valid_seen", {31'd0, bus.rsp_valid}, 32'd1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("latency", lat, e.lat);
            check("rsp_data", {24'd0, bus.rsp_data}, {24'd0, e.data});
            check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        end
        if (handshake) begin
            bus.rsp_ready = 1'b1;
            step();
            bus.rsp_ready = 1'b0;
            check("rsp_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
            check("req_ready_back", {31'd0, bus.req_ready}, 32'd1);
        end
    endtask

    initial begin
        int unsigned lat, pass_lat;
        logic [7:0] held_data, held_i1;
        bit seen;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_opcode = 2'b00;
        bus.req_i1     = 8'h00;
        bus.req_i2     = 8'h00;
        bus.rsp_ready  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
        check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check("rst_alu", {14'd0, bus.alu_opcode, bus.alu_i1, bus.alu_i2}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // First add: no opcode-change penalty when tracked.
        issue(2'b00, 8'h12, 8'h34);
        collect(1'b1, lat);
`ifdef ALU_SEQ_OPC_TRACK_EN
        check("add_first_lat", lat, 32'd4);
`else
        check("add_first_lat", lat, 32'd5);
`endif
        issue(2'b01, 8'hA5, 8'h5A);
        collect(1'b1, pass_lat);
        check("pass_i1_lat", pass_lat, 32'd3);

        issue(2'b10, 8'h11, 8'h3C);
        collect(1'b1, lat);
        issue(2'b10, 8'h22, 8'h3C);
        collect(1'b1, lat);
`ifdef ALU_SEQ_OPC_TRACK_EN
        check("pass_i2_repeat_lat", lat, 32'd2);
`else
        check("pass_i2_repeat_lat", lat, 32'd3);
`endif
        // Reserved opcode: same busy time as a pass op that changes opcode.
        issue(2'b11, 8'h77, 8'h88);
        collect(1'b1, lat);
        check("op11_lat_vs_pass", lat, pass_lat);

        // Backpressure: RESP held while requests are offered.
        issue(2'b00, 8'h10, 8'h20);
        collect(1'b0, lat);
        held_data = bus.rsp_data;
        for (int i = 0; i < 10; i++) begin
            bus.req_valid  = 1'b1;
            bus.req_opcode = 2'b01;
            bus.req_i1     = 8'($urandom_range(0, 255));
            step();
            check("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_rsp_data", {24'd0, bus.rsp_data}, {24'd0, held_data});
            check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            check("bp_alu", {14'd0, bus.alu_opcode, bus.alu_i1, bus.alu_i2}, 32'h0000_1020);
        end
        bus.rsp_ready = 1'b1;
        held_i1       = bus.alu_i1;
        step();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check("bp_no_accept_on_rsp", {31'd0, busy}, 32'd0);
        check("bp_alu_i1_kept", {24'd0, bus.alu_i1}, {24'd0, held_i1});

        // Reset during SETTLE discards the transaction.
        issue(2'b00, 8'h40, 8'h02);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        tb_last_op = 2'b00;
        check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mid_rst_alu_opcode", {30'd0, bus.alu_opcode}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("mid_rst_no_rsp", {31'd0, seen}, 32'd0);

        issue(2'b00, 8'h01, 8'h02);
        collect(1'b1, lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the 8-bit opcode-selected ALU datapath, whose pass-through paths are fast, whose add path is slow, and which needs extra settle time after an opcode change.
- Accepts operation requests over valid/ready, drives the ALU operand and opcode inputs, and waits an opcode-dependent number of settle cycles.
- Captures the ALU output and returns it over a valid/ready response channel.
- Sits between the control pipeline and the combinational ALU instance.

Parameters:
- WIDTH, 8, operand/result width.
- ADD_WAIT, 3, settle cycles for opcode 2'b00 (add).
- PASS_WAIT, 1, settle cycles for opcodes 2'b01/2'b10 (pass i1/i2) and 2'b11.
- OPC_WAIT, 1, extra settle cycles charged when the opcode changes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_opcode  in  2  operation: 00 add, 01 pass i1, 10 pass i2, 11 reserved.
- req_i1  in  WIDTH  operand 1.
- req_i2  in  WIDTH  operand 2.
- alu_i1  out  WIDTH  drives ALU i1.
- alu_i2  out  WIDTH  drives ALU i2.
- alu_opcode  out  2  drives ALU opcode.
- alu_o1  in  WIDTH  ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_data  out  WIDTH  captured result.
- rsp_err  out  1  request used reserved opcode 11.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; alu_i1=0; alu_i2=0; alu_opcode=2'b00; last_op=2'b00; busy=0.
- States: IDLE -> SETTLE -> RESP -> IDLE.
- IDLE:
  - req_ready=1.
  - On accept at edge T: register operands/opcode onto alu_* (visible from cycle T+1).
  - Load counter with N, set rsp_err=(opcode==11), update last_op, go to SETTLE.
- Computing N:
  - base = ADD_WAIT for 00, PASS_WAIT otherwise.
  - N = base + OPC_WAIT, or base alone; see Optional Feature.
  - If the computed N is 0, use N=1.
- SETTLE:
  - req_ready=0; alu_* held stable.
  - Counter decrements each cycle.
  - On the last SETTLE cycle (counter==1), sample alu_o1 into rsp_data at the clock edge and go to RESP.
  - Opcode 11: rsp_data is forced to 0 instead of sampling alu_o1.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err held.
  - On rsp_ready, go to IDLE; rsp_valid drops next cycle.
  - No request is accepted in the same cycle as the response handshake.
- Latency: accept at edge T -> rsp_valid first high in cycle T+N+1 (measured in cycles after the edge).
- Backpressure: rsp_ready low holds RESP indefinitely; alu_* keep the last values.
- alu_* change only on request acceptance, never otherwise. This keeps the ALU inputs glitch-free between operations.
- Reset asserted mid-SETTLE or mid-RESP: the transaction is discarded with no response, and all outputs return to reset values on the next edge.
- Counter width: clog2(ADD_WAIT+PASS_WAIT+OPC_WAIT+2) bits; no wrap is possible.

Optional Feature:
- Macro: ALU_SEQ_OPC_TRACK_EN.
- Defined: OPC_WAIT is added only when req_opcode differs from last_op. last_op resets to 00, so the first add after reset pays no penalty.
- Undefined: OPC_WAIT is added on every request and last_op is not implemented. This is the conservative timing.

Test Plan:
- Reset, then add i1=8'h12, i2=8'h34, with a bench ALU model returning 8'h46 -> alu_opcode=00.
  - Macro on: rsp_valid at T+4, rsp_data=8'h46, rsp_err=0.
  - Macro off: rsp_valid at T+5.
- Add, then pass-i1 (i1=8'hA5) -> opcode change gives N=2; rsp_valid at T+3, rsp_data=8'hA5, in both builds.
- Two consecutive pass-i2 requests (i2=8'h3C) with the macro on -> second request has N=1, rsp_valid at T+2, rsp_data=8'h3C.
- Opcode 11 request -> rsp_err=1, rsp_data=0, busy cycle count identical to a pass operation.
- rsp_ready held low 10 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0, req_valid ignored, alu_* unchanged.
- rst pulsed during SETTLE of an add -> next cycle: IDLE, req_ready=1, rsp_valid=0, alu_opcode=00, no response ever issued.
